// File: rtl/urv_imem_bridge_if.sv
// Fetch-side and memory-side signals of the instruction memory bridge.
// The slave modport is the bridge; the master modport is the core/memory side.
interface urv_imem_bridge_if;
    logic [31:0] im_addr_i;
    logic [31:0] im_data_o;
    logic        im_valid_o;
    logic        inv_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;

    modport slave (
        input  im_addr_i, inv_i, mem_ack_i, mem_data_i,
        output im_data_o, im_valid_o, mem_req_o, mem_addr_o
    );

    modport master (
        output im_addr_i, inv_i, mem_ack_i, mem_data_i,
        input  im_data_o, im_valid_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/urv_imem_bridge.sv
// Single-request instruction fetch bridge with a tiny word buffer and ack bypass.
// Define URV_IMEM_PREFETCH_EN for a two-entry buffer with sequential next-word prefetch.
module urv_imem_bridge (
    input  logic             clk_i,
    input  logic             rst_n_i,
    urv_imem_bridge_if.slave bus
);

`ifdef URV_IMEM_PREFETCH_EN
    localparam int NUM_ENT = 2;
`else
    localparam int NUM_ENT = 1;
`endif

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [29:0]          r_addr_q;
    logic                 r_fetch_vld;
    logic                 r_mem_req;
    logic [29:0]          r_mem_addr;
    logic                 r_drop;
    logic                 r_ent_vld  [NUM_ENT];
    logic [29:0]          r_ent_tag  [NUM_ENT];
    logic [31:0]          r_ent_data [NUM_ENT];

    logic [NUM_ENT-1:0]   w_hit_vec;
    logic [NUM_ENT-1:0]   w_we;
    logic                 w_hit;
    logic [31:0]          w_hit_data;
    logic                 w_ack_busy;
    logic                 w_fill;
    logic                 w_bypass;
    logic                 w_issue;
    logic [29:0]          w_issue_addr;
    logic                 w_unused_lsb;

    // Only word addresses matter; the byte offset of the fetch address is ignored.
    assign w_unused_lsb = ^bus.im_addr_i[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENT; gi++) begin : g_hit
            assign w_hit_vec[gi] = r_ent_vld[gi] && (r_ent_tag[gi] == r_addr_q);
        end
    endgenerate

    assign w_hit = |w_hit_vec;

    always_comb begin
        w_hit_data = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (w_hit_vec[i]) begin
                w_hit_data = r_ent_data[i];
            end
        end
    end

    // A fill is kept only if no invalidate arrived while it was outstanding.
    assign w_ack_busy = (r_state == BUSY) && bus.mem_ack_i;
    assign w_fill     = w_ack_busy && !r_drop && !bus.inv_i;
    assign w_bypass   = w_fill && (r_mem_addr == r_addr_q);

`ifdef URV_IMEM_PREFETCH_EN
    logic               r_repl;
    logic [29:0]        w_pf_addr;
    logic [NUM_ENT-1:0] w_pf_vec;
    logic               w_pf_hit;

    assign w_pf_addr = r_addr_q + 30'd1;

    generate
        for (gi = 0; gi < NUM_ENT; gi++) begin : g_pf
            assign w_pf_vec[gi] = r_ent_vld[gi] && (r_ent_tag[gi] == w_pf_addr);
            assign w_we[gi]     = w_fill && (r_repl == 1'(gi));
        end
    endgenerate

    assign w_pf_hit = |w_pf_vec;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_repl <= 1'b0;
        end else if (w_fill) begin
            r_repl <= ~r_repl;
        end
    end
`else
    assign w_we[0] = w_fill;
`endif

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_issue_addr = r_addr_q;
        case (r_state)
            IDLE: begin
                if (r_fetch_vld && !w_hit) begin
                    w_issue      = 1'b1;
                    w_state_next = BUSY;
                end
`ifdef URV_IMEM_PREFETCH_EN
                else if (w_hit && !w_pf_hit) begin
                    w_issue      = 1'b1;
                    w_issue_addr = w_pf_addr;
                    w_state_next = BUSY;
                end
`endif
            end
            BUSY: begin
                if (bus.mem_ack_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_addr_q    <= '0;
            r_fetch_vld <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_addr_q    <= bus.im_addr_i[31:2];
            r_fetch_vld <= 1'b1;
            if (w_issue) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= w_issue_addr;
            end else if (w_ack_busy) begin
                r_mem_req  <= 1'b0;
            end
            if (r_state == BUSY) begin
                r_drop <= !bus.mem_ack_i && (r_drop || bus.inv_i);
            end else begin
                r_drop <= 1'b0;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_ENT; gi++) begin : g_ent
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_ent_vld[gi]  <= 1'b0;
                    r_ent_tag[gi]  <= '0;
                    r_ent_data[gi] <= '0;
                end else begin
                    if (bus.inv_i) begin
                        r_ent_vld[gi] <= 1'b0;
                    end else if (w_we[gi]) begin
                        r_ent_vld[gi] <= 1'b1;
                    end
                    if (w_we[gi]) begin
                        r_ent_tag[gi]  <= r_mem_addr;
                        r_ent_data[gi] <= bus.mem_data_i;
                    end
                end
            end
        end
    endgenerate

    assign bus.mem_req_o  = r_mem_req;
    assign bus.mem_addr_o = {r_mem_addr, 2'b00};
    assign bus.im_valid_o = w_hit || w_bypass;
    assign bus.im_data_o  = w_hit ? w_hit_data : (w_bypass ? bus.mem_data_i : 32'h0);

endmodule

// File: doc/urv_imem_bridge.md
URV_IMEM_BRIDGE -- requirements
Module: urv_imem_bridge

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk_i  input  1  sole clock, all state on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 im_addr_i  input  32  fetch address (fetch stage pc_next), presented every cycle.
REQ-005 im_data_o  output  32  instruction word for the address presented on the previous cycle.
REQ-006 im_valid_o  output  1  im_data_o valid this cycle.
REQ-007 inv_i  input  1  one-cycle pulse, invalidate all buffered words (fence.i).
REQ-008 mem_req_o  output  1  registered bus request, held until ack.
REQ-009 mem_addr_o  output  32  registered word address, bits [1:0] always 0, stable while mem_req_o high.
REQ-010 mem_ack_i  input  1  request complete, mem_data_i valid this cycle.
REQ-011 mem_data_i  input  32  read data.

Function
REQ-012 addr_q SHALL register im_addr_i every cycle; all tag compares SHALL use bits [31:2] only.
REQ-013 Buffer entry = {valid, tag[31:2], data[31:0]}; hit = valid and tag == addr_q[31:2].
REQ-014 On hit, im_valid_o SHALL be 1 and im_data_o SHALL be the entry data (address at cycle N, data at N+1).
REQ-015 FSM states: IDLE, BUSY; one outstanding bus request max.
REQ-016 IDLE and addr_q misses: next edge sets mem_req_o=1, mem_addr_o={addr_q[31:2],2'b00}, state BUSY.
REQ-017 BUSY: mem_req_o/mem_addr_o held until mem_ack_i; on ack, entry written (valid=1), mem_req_o=0, state IDLE at same edge.
REQ-018 Bypass: in BUSY with mem_ack_i=1 and mem_addr_o[31:2]==addr_q[31:2], im_valid_o=1, im_data_o=mem_data_i in that cycle.
REQ-019 Miss latency with w wait cycles: address at N, req at N+2, ack at N+2+w, im_valid_o at N+2+w.
REQ-020 Outstanding request SHALL NOT be aborted when im_addr_i changes (branch); the fill completes and is stored, then the new miss issues from IDLE.
REQ-021 im_valid_o SHALL be 0 on every cycle with neither hit nor bypass.
REQ-022 inv_i SHALL clear all valid bits at next edge; a fill acked in the same cycle as inv_i, or while BUSY after inv_i, SHALL be discarded (not written, no bypass).
REQ-023 inv_i and hit in same cycle: im_valid_o still 1 that cycle; 0 from next cycle until refilled.
REQ-024 Address wrap: addr_q=0xFFFFFFFC handled as normal word; prefetch address (REQ-029) wraps to 0x00000000.

Reset
REQ-025 While rst_n_i low: mem_req_o=0, mem_addr_o=0, addr_q=0, state IDLE, all valid=0, im_valid_o=0, im_data_o=0.
REQ-026 Reset mid-transaction SHALL abandon the request with no fill; a late mem_ack_i after reset SHALL be ignored in IDLE.
REQ-027 First fetch after reset release SHALL miss and follow REQ-016.

Configuration
REQ-028 Macro URV_IMEM_PREFETCH_EN selects sequential prefetch.
REQ-029 With it: two entries, fill replaces entry pointed by a replace pointer that toggles per fill; in IDLE with addr_q hit and (addr_q+4) missing, issue prefetch of addr_q+4 as REQ-016; demand miss has priority over prefetch in IDLE.
REQ-030 Without it: one entry, requests issued only on demand miss; no prefetch logic present.

Verification
REQ-031 Reset release, hold im_addr_i=0x0, mem acks 2 cycles after req with 0x00000013 -> req at cycle 2, im_valid_o=1 data 0x00000013 at cycle 4 via bypass, then every cycle from buffer.
REQ-032 Present 0x100 hit, 0x100 repeated 5 cycles -> im_valid_o=1 each cycle, no mem_req_o.
REQ-033 Miss on 0x200 in BUSY, switch im_addr_i to 0x400 -> 0x200 completes and stored, then req 0x400; im_valid_o=0 until 0x400 ack.
REQ-034 inv_i pulsed in ack cycle of 0x300 -> no bypass, entry not valid, 0x300 re-requested.
REQ-035 With URV_IMEM_PREFETCH_EN, sequential 0x0,0x4,0x8 with 0-wait memory -> after 0x0 fill, prefetch 0x4 issued; 0x4 hits with no demand miss.
REQ-036 Assert rst_n_i low while BUSY, ack arrives during reset -> all outputs reset values, no entry valid after release.
